// File: rtl/solar_pkg.sv
// Shared constants for the solar telemetry display path: scan modes and channel map.
// Pure declarations; no logic, no latency.
package solar_pkg;

  localparam logic SCAN_MANUAL     = 1'b0;
  localparam logic SCAN_AUTO       = 1'b1;

  localparam int   DISP_WIDTH      = 12;
  localparam int   DISP_CH_DEFAULT = 5;

  localparam int   CH_VOLT         = 0;
  localparam int   CH_CURR         = 1;
  localparam int   CH_PWR          = 2;
  localparam int   CH_TEMP         = 3;
  localparam int   CH_EFF          = 4;

  typedef enum logic {
    MODE_MANUAL = SCAN_MANUAL,
    MODE_AUTO   = SCAN_AUTO
  } scan_mode_e;

endpackage

// File: rtl/solar_dwell_timer.sv
// Auto-scan dwell counter 0..DWELL_CYCLES-1; o_tc is a compare on the count register.
// Clear has priority; at terminal count the counter saturates until cleared.
module solar_dwell_timer #(
  parameter int DWELL_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int               CNT_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/solar_display_sequencer.sv
// Channel sequencer for the display driver: auto-scan or manual capture, 1-cycle capture latency.
// Backpressure: a capture waits for a free output slot; dwell saturates, manual requests merge.
module solar_display_sequencer
  import solar_pkg::*;
#(
  parameter  int WIDTH        = DISP_WIDTH,
  parameter  int NUM_CH       = DISP_CH_DEFAULT,
  parameter  int DWELL_CYCLES = 1024,
  localparam int SEL_W        = $clog2(NUM_CH)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        man_sel,
  input  logic                    man_req,
  input  logic                    hold,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  scan_mode_e       r_mode;
  scan_mode_e       r_mode_prev;
  logic [SEL_W-1:0] r_ptr;
  logic             r_pend;

  logic             w_slot_free;
  logic             w_mode_chg;
  logic             w_run;
  logic             w_tc;
  logic             w_cap_auto;
  logic             w_cap_man;
  logic             w_cap;
  logic             w_sel_bad;
  logic [SEL_W-1:0] w_cap_sel;
  logic [WIDTH-1:0] w_cap_dat;

  always_comb begin
    w_slot_free = !out_valid || out_ready;
    w_mode_chg  = (r_mode != r_mode_prev);
    w_run       = !hold && !w_mode_chg;
    w_cap_auto  = w_run && (r_mode == MODE_AUTO) && w_tc && w_slot_free;
    w_cap_man   = w_run && (r_mode == MODE_MANUAL) && r_pend && w_slot_free;
    w_cap       = w_cap_auto || w_cap_man;
    w_sel_bad   = (man_sel > LAST_CH);
    // Out-of-range manual selects fall back to channel 0 and raise sel_err.
    if (w_cap_man) begin
      w_cap_sel = w_sel_bad ? '0 : man_sel;
    end else begin
      w_cap_sel = r_ptr;
    end
  end

  always_comb begin
    w_cap_dat = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_cap_sel == SEL_W'(k)) begin
        w_cap_dat = ch_data[k*WIDTH +: WIDTH];
      end
    end
  end

  solar_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (w_mode_chg || w_cap_auto),
    .i_en  ((r_mode == MODE_AUTO) && !hold),
    .o_tc  (w_tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mode      <= MODE_MANUAL;
      r_mode_prev <= MODE_MANUAL;
      r_ptr       <= '0;
      r_pend      <= 1'b0;
    end else begin
      r_mode      <= scan_mode_e'(mode);
      r_mode_prev <= r_mode;
      if (w_mode_chg) begin
        r_ptr  <= '0;
        r_pend <= 1'b0;
      end else begin
        if (w_cap_auto) begin
          r_ptr <= (r_ptr == LAST_CH) ? '0 : r_ptr + SEL_W'(1);
        end
        // A request arriving in the capture cycle re-arms pending for a fresh capture.
        r_pend <= (r_pend && !w_cap_man) || man_req;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      if (w_cap) begin
        out_data  <= w_cap_dat;
        out_ch    <= w_cap_sel;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_cap_man && w_sel_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_solar_display_sequencer.sv
// Scoreboarded directed bench for solar_display_sequencer (WIDTH=12, NUM_CH=5, DWELL_CYCLES=4).
module tb_solar_display_sequencer;

  localparam int WIDTH  = 12;
  localparam int NUM_CH = 5;
  localparam int DWELL  = 4;
  localparam int SEL_W  = $clog2(NUM_CH);

  typedef struct {
    logic [WIDTH-1:0] dat;
    logic [SEL_W-1:0] ch;
  } exp_t;

  logic                    wb_clk_i = 1'b0;
  logic                    wb_rst_i;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic                    mode;
  logic [SEL_W-1:0]        man_sel;
  logic                    man_req;
  logic                    hold;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  solar_display_sequencer #(
    .WIDTH        (WIDTH),
    .NUM_CH       (NUM_CH),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .ch_data   (ch_data),
    .mode      (mode),
    .man_sel   (man_sel),
    .man_req   (man_req),
    .hold      (hold),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic push(input int k);
    exp_t e;
    e.dat = WIDTH'(12'h100 + k);
    e.ch  = SEL_W'(k);
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted word must match the head of the expected queue.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {20'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", {20'd0, out_data}, {20'd0, e.dat});
        chk("sb_ch", {29'd0, out_ch}, {29'd0, e.ch});
      end
    end
  end

  initial begin
    for (int k = 0; k < NUM_CH; k++) ch_data[k*WIDTH +: WIDTH] = WIDTH'(12'h100 + k);
    wb_rst_i = 1'b1; mode = 1'b0; man_sel = '0; man_req = 1'b0; hold = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {20'd0, out_data}, 32'd0);
    chk("rst_ch", {29'd0, out_ch}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
    wb_rst_i = 1'b0;

    // 1: auto scan, captures every DWELL cycles with wrap 4 -> 0
    for (int k = 0; k < NUM_CH; k++) push(k);
    push(0);
    mode = 1'b1; out_ready = 1'b1;
    repeat (26) tick();
    chk("t1_wrap_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_wrap_ch", {29'd0, out_ch}, 32'd0);

    // 2: backpressure holds word ch0; ch1 captured on the accept edge
    out_ready = 1'b0;
    push(1); push(2);
    repeat (12) tick();
    chk("t2_held_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_held_data", {20'd0, out_data}, 32'h100);
    out_ready = 1'b1;
    tick();
    chk("t2_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_accept_ch", {29'd0, out_ch}, 32'd1);
    chk("t2_accept_data", {20'd0, out_data}, 32'h101);
    repeat (4) tick();
    chk("t2_next_ch", {29'd0, out_ch}, 32'd2);
    mode = 1'b0;
    repeat (3) tick();

    // 3: manual capture of ch3, then out-of-range select
    push(3);
    man_sel = 3'd3; man_req = 1'b1;
    tick();
    man_req = 1'b0;
    tick();
    chk("t3_man_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_man_data", {20'd0, out_data}, 32'h103);
    chk("t3_man_ch", {29'd0, out_ch}, 32'd3);
    tick();
    push(0);
    man_sel = 3'd7; man_req = 1'b1;
    tick();
    man_req = 1'b0;
    tick();
    chk("t3_bad_ch", {29'd0, out_ch}, 32'd0);
    chk("t3_bad_data", {20'd0, out_data}, 32'h100);
    chk("t3_sel_err", {31'd0, sel_err}, 32'd1);
    repeat (2) tick();
    chk("t3_sel_err_sticky", {31'd0, sel_err}, 32'd1);

    // 4: merged manual requests under backpressure -> exactly one extra capture
    out_ready = 1'b0;
    push(1); push(2);
    man_sel = 3'd1; man_req = 1'b1;
    tick();
    man_req = 1'b0;
    tick();
    chk("t4_first_ch", {29'd0, out_ch}, 32'd1);
    man_sel = 3'd2;
    repeat (3) begin
      man_req = 1'b1; tick();
      man_req = 1'b0; tick();
    end
    chk("t4_held_data", {20'd0, out_data}, 32'h101);
    out_ready = 1'b1;
    tick();
    chk("t4_swap_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_swap_ch", {29'd0, out_ch}, 32'd2);
    repeat (6) tick();
    chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_sel_err_sticky", {31'd0, sel_err}, 32'd1);

    // 5: hold mid-dwell freezes the scan; remaining dwell completes after release
    push(0); push(1);
    mode = 1'b1;
    repeat (6) tick();
    chk("t5_first_ch", {29'd0, out_ch}, 32'd0);
    repeat (2) tick();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold_no_capture", {31'd0, out_valid}, 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("t5_remaining_dwell", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t5_resume_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_resume_ch", {29'd0, out_ch}, 32'd1);

    // 6: reset with a held word mid-dwell; scan restarts at ch0 after a full dwell
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_pre_ch", {29'd0, out_ch}, 32'd2);
    tick();
    wb_rst_i = 1'b1;
    tick();
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_data", {20'd0, out_data}, 32'd0);
    chk("t6_rst_ch", {29'd0, out_ch}, 32'd0);
    chk("t6_rst_sel_err", {31'd0, sel_err}, 32'd0);
    wb_rst_i = 1'b0; out_ready = 1'b1;
    push(0);
    repeat (5) tick();
    chk("t6_restart_wait", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t6_restart_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_restart_data", {20'd0, out_data}, 32'h100);
    mode = 1'b0;
    repeat (4) tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
